// File: rtl/dmem_responder.sv
// Data-memory responder: services single-word read/write requests from an internal RAM after LATENCY wait states.
// Optional DMEM_ERR_EN adds the err port and misaligned-access checking.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] memory_addr,
  input  logic [31:0] data_to_write,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        stall
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN   = 33'(1) << (DEPTH_LOG2 + 2);
  localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        rd_q, wr_q, ready_q, stall_q;
  logic [31:0] mem [DEPTH];

  logic [31:0]           cur_addr, cur_wdata, offset;
  logic                  cur_rd, cur_wr, oor, mis, both, commit, wr_ok;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_ok;

  // With zero latency the commit happens on the accepting edge, so use live inputs.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    if (state_q == IDLE) begin
      cur_addr  = memory_addr;
      cur_wdata = data_to_write;
      cur_rd    = read;
      cur_wr    = write;
    end
  end

  assign offset    = cur_addr - BASE_ADDR;
  assign idx       = offset[DEPTH_LOG2+1:2];
  assign oor       = {1'b0, offset} >= SPAN;
  assign both      = cur_rd & cur_wr;
  assign unused_ok = ^offset[1:0];
`ifdef DMEM_ERR_EN
  assign mis = |cur_addr[1:0];
`else
  assign mis = 1'b0;
`endif
  assign wr_ok  = cur_wr & ~cur_rd & ~oor & ~mis;
  assign commit = ((state_q == IDLE) && (read | write) && (LATENCY == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

`ifdef DMEM_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)  err_q <= 1'b0;
    else      err_q <= commit & (both | oor | mis);
  end
  assign err = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (read | write) begin
          addr_q  <= memory_addr;
          wdata_q <= data_to_write;
          rd_q    <= read;
          wr_q    <= write;
          if (LATENCY > 0) begin
            state_q <= WAIT;
            cnt_q   <= LAT_M1;
            stall_q <= 1'b1;
          end
        end
        WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Entering RESP is the commit point; read&write leaves read_data untouched.
      if (commit) begin
        state_q <= RESP;
        ready_q <= 1'b1;
        stall_q <= 1'b0;
        if (cur_rd && !cur_wr) rdata_q <= (oor || mis) ? 32'd0 : mem[idx];
      end
    end
  end

  // RAM contents survive reset; an aborted write never reaches here.
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_ok) mem[idx] <= cur_wdata;
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, DEPTH_LOG2=10); err checks compile in with DMEM_ERR_EN.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst, read, write, ready, stall;
  logic [31:0] memory_addr, data_to_write, read_data;
`ifdef DMEM_ERR_EN
  logic        err;
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .memory_addr(memory_addr), .data_to_write(data_to_write),
    .read_data(read_data), .ready(ready), .stall(stall)
`ifdef DMEM_ERR_EN
    , .err(err)
`endif
  );

  typedef struct packed { logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("read_data", read_data, e.data);
`ifdef DMEM_ERR_EN
        chk("err", {31'd0, err}, {31'd0, e.err});
`endif
      end
    end
  end

  // One-cycle request, then check the stall/ready timing of the whole access.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    read = rd; write = wr; memory_addr = a; data_to_write = d;
    sb.push_back('{exp_data, exp_err});
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_ready", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    chk("resp_ready", {31'd0, ready}, 32'd1);
    chk("resp_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [6:0] pat;
    rst = 1'b1; read = 1'b0; write = 1'b0; memory_addr = 32'd0; data_to_write = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rdata", read_data, 32'd0);
      chk("idle_ctl", {30'd0, ready, stall}, 32'd0);
    end

    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Held through ready: second acceptance follows the IDLE cycle after RESP.
    pat = 7'b1000100;
    @(negedge clk);
    read = 1'b1; memory_addr = 32'h10;
    sb.push_back('{32'hDEAD_BEEF, 1'b0});
    sb.push_back('{32'hDEAD_BEEF, 1'b0});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("b2b_ready", {31'd0, ready}, {31'd0, pat[i]});
    end
    read = 1'b0;
    @(negedge clk);
    chk("b2b_done", {30'd0, ready, stall}, 32'd0);

    access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0);

    // Abort a write during WAIT.
    @(negedge clk);
    write = 1'b1; memory_addr = 32'h20; data_to_write = 32'h1234_5678;
    @(posedge clk); #1 write = 1'b0;
    @(negedge clk);
    chk("abort_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdata", read_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_noready", {30'd0, ready, stall}, 32'd0);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);

    access(1'b0, 1'b1, 32'h0, 32'h1111_2222, 32'hCAFE_F00D, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, ERR);
    access(1'b1, 1'b0, 32'h0, 32'h0, 32'h1111_2222, 1'b0);
    access(1'b1, 1'b0, 32'h2, 32'h0, ERR ? 32'h0 : 32'h1111_2222, ERR);
    access(1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, ERR);
    access(1'b0, 1'b1, 32'h1010, 32'h55AA_55AA, 32'h0, ERR);
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
